press_arbiter: RTL and testbench
================================

Name: press_arbiter

Overview:
- Clocked, parametrised successor to the two-button tug-of-war push-button latch.
- Arbitrates N player buttons per round: first rising press wins and locks out the others.
- Presses arriving within a configurable window after the first are declared a tie.
- Sits between the raw debounced button inputs and the game scoring/display logic. Holds the result until the round is cleared.

Parameters:
- N_PLAYERS, 2, number of button inputs (2..16).
- SYNC_STAGES, 2, flip-flop synchroniser depth per button (>=2).
- TIE_WINDOW, 0, extra cycles after the first accepted press during which further presses join a tie (0 = same-cycle only; max 255).
- IDX_W, $clog2(N_PLAYERS) (min 1), width of winner_idx.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset; one clock, all state cleared on assertion.
- clr  in  1  synchronous round clear (active-high), re-arms the arbiter.
- pb  in  N_PLAYERS  raw button levels, asynchronous to clk, bit i = player i.
- push  out  1  registered OR of synchronised button levels.
- done  out  1  round result valid and held.
- tie  out  1  result is a tie (two or more winners).
- winner_onehot  out  N_PLAYERS  bit set for every player in the result set.
- winner_idx  out  IDX_W  lowest-indexed player in the result set.
- right  out  1  N_PLAYERS==2 compatibility: done & ~tie & winner_onehot[1]; tie to 0 when N_PLAYERS!=2.

Behaviour:
- Reset values: all outputs 0, synchronisers 0, edge-history 0, FSM = ARMED, window counter 0.
- Input path:
  - Each pb bit passes through SYNC_STAGES flops giving s[i].
  - prev[i] registers s[i] each cycle.
  - A rise is rise[i] = s[i] & ~prev[i]. Only rises are events; held levels never trigger.
- push = registered |s; 1-cycle lag behind s. Independent of FSM state.
- FSM, 3 states:
  - ARMED:
    - Clear winner_onehot, done, tie.
    - If any rise: capture winner_onehot <= rise.
    - If TIE_WINDOW==0, go to LOCKED. Otherwise load counter = TIE_WINDOW and go to WINDOW.
  - WINDOW:
    - Each cycle winner_onehot <= winner_onehot | rise; counter decrements.
    - When the counter reaches 1 and is decremented, go to LOCKED. Rises in that final cycle are still OR'd in.
  - LOCKED:
    - done=1; tie = (popcount(winner_onehot) >= 2); winner_idx = index of lowest set bit.
    - All further rises ignored. Hold until clr.
- done, tie and winner_idx update together, registered, on entry to LOCKED. No partial result is visible in WINDOW.
- Latency: pb high sampled at edge k -> s high after edge k+SYNC_STAGES-1 -> FSM captures at edge k+SYNC_STAGES -> done visible after edge k+SYNC_STAGES+TIE_WINDOW.
- clr, any state:
  - Next state ARMED; done/tie/winner_onehot/winner_idx <= 0; counter <= 0.
  - prev <= s, so buttons held through clr do not fire on re-arm.
  - clr has priority over a same-cycle rise; that rise is discarded.
- Simultaneous rises in the capturing cycle: all of them enter the result set, so tie=1 when two or more.
- rst asserted mid-round: immediate return to reset values. After release, the FSM is ARMED with prev=0, so a button held through reset registers a rise once synchronised. This is intentional: reset is power-on only; clr is the round control.
- No overflow cases: the counter is 8 bits, and winner_idx is always in range since only set bits are encoded.

Test Plan:
- N=2, W=0, SYNC=2: pb=01 at edge 10, held -> done=1 after edge 12, winner_onehot=01, winner_idx=0, tie=0, right=0. Later pb=11 -> no change.
- N=2, W=0: pb goes 00->11 in one cycle -> done=1, tie=1, winner_onehot=11, winner_idx=0, right=0.
- N=4, W=3: pb[2] rises at edge 20, pb[0] at edge 22, pb[3] at edge 30 -> done after edge 25, winner_onehot=0101, tie=1, winner_idx=0. pb[3] is ignored.
- clr while pb[1] is held: after clr, done=0 and no capture. Release then re-press pb[1] -> win, winner_idx=1, right=1 (N=2).
- clr asserted the same cycle as a rise of pb[0] -> result discarded, done stays 0. pb[1] pressed later wins alone.
- rst asserted in WINDOW (N=4, W=5) -> all outputs 0 immediately, async. After release, a fresh press of pb[3] gives winner_idx=3 with latency SYNC_STAGES+W.

Source files
------------

// File: rtl/press_arbiter_if.sv
// Button-arbiter bus: raw buttons and round clear in, round result out.
interface press_arbiter_if #(
  parameter int N_PLAYERS = 2,
  parameter int IDX_W     = 1
);
  logic                 clr;
  logic [N_PLAYERS-1:0] pb;
  logic                 push;
  logic                 done;
  logic                 tie;
  logic [N_PLAYERS-1:0] winner_onehot;
  logic [IDX_W-1:0]     winner_idx;
  logic                 right;

  // Game controller side: drives buttons and clear, observes the result.
  modport master (
    output clr, pb,
    input  push, done, tie, winner_onehot, winner_idx, right
  );

  // Arbiter side.
  modport slave (
    input  clr, pb,
    output push, done, tie, winner_onehot, winner_idx, right
  );
endinterface

// File: rtl/press_arbiter.sv
// N-player first-press arbiter with optional tie window.
// Buttons are synchronised and edge-detected; the first rising press(es)
// open a round, further rises inside the tie window join it, and the result
// is held until a synchronous round clear.
module press_arbiter #(
  parameter int N_PLAYERS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIE_WINDOW  = 0,
  parameter int IDX_W       = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  press_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_WINDOW = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_PLAYERS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      r = v[i] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  // True when two or more bits are set (clearing the lowest bit leaves some).
  function automatic logic multi_hot(input logic [N_PLAYERS-1:0] v);
    return (v & (v - {{(N_PLAYERS-1){1'b0}}, 1'b1})) != '0;
  endfunction

  logic [SYNC_STAGES-1:0][N_PLAYERS-1:0] sync_q, sync_d;
  logic [N_PLAYERS-1:0] prev_q, prev_d;
  logic [N_PLAYERS-1:0] sync_s, rise_s, acc_s;
  logic                 push_q, push_d;
  logic                 res_tie_s, res_right_s;
  logic [IDX_W-1:0]     res_idx_s;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [N_PLAYERS-1:0] onehot_q, onehot_d;
  logic                 done_q, done_d;
  logic                 tie_q, tie_d;
  logic                 right_q, right_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Synchroniser shift, edge history and button-activity indicator.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.pb};
    sync_s = sync_q[SYNC_STAGES-1];
    prev_d = sync_s;
    rise_s = sync_s & ~prev_q;
    push_d = |sync_s;
  end

  // Candidate result set for this cycle and its decoded summary.
  always_comb begin
    acc_s       = (state_q == ST_ARMED) ? rise_s : (onehot_q | rise_s);
    res_tie_s   = multi_hot(acc_s);
    res_idx_s   = lowest_idx(acc_s);
    res_right_s = (N_PLAYERS == 2) && !res_tie_s && acc_s[1];
  end

  // Round FSM next-state and next-result logic; clear wins over any rise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    done_d   = done_q;
    tie_d    = tie_q;
    idx_d    = idx_q;
    right_d  = right_q;
    if (bus.clr) begin
      state_d  = ST_ARMED;
      cnt_d    = 8'd0;
      onehot_d = '0;
      done_d   = 1'b0;
      tie_d    = 1'b0;
      idx_d    = '0;
      right_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          onehot_d = '0;
          done_d   = 1'b0;
          tie_d    = 1'b0;
          idx_d    = '0;
          right_d  = 1'b0;
          if (|rise_s) begin
            onehot_d = acc_s;
            if (TIE_WINDOW == 0) begin
              state_d = ST_LOCKED;
              done_d  = 1'b1;
              tie_d   = res_tie_s;
              idx_d   = res_idx_s;
              right_d = res_right_s;
            end else begin
              state_d = ST_WINDOW;
              cnt_d   = 8'(TIE_WINDOW);
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_WINDOW: begin
          onehot_d = acc_s;
          cnt_d    = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_LOCKED;
            done_d  = 1'b1;
            tie_d   = res_tie_s;
            idx_d   = res_idx_s;
            right_d = res_right_s;
          end else begin
            state_d = ST_WINDOW;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        default: begin
          state_d  = ST_ARMED;
          cnt_d    = 8'd0;
          onehot_d = '0;
          done_d   = 1'b0;
          tie_d    = 1'b0;
          idx_d    = '0;
          right_d  = 1'b0;
        end
      endcase
    end
  end

  // Input-path registers: synchroniser chain, previous level, push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      push_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      push_q <= push_d;
    end
  end

  // Round FSM state, window counter and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ARMED;
      cnt_q    <= 8'd0;
      onehot_q <= '0;
      done_q   <= 1'b0;
      tie_q    <= 1'b0;
      idx_q    <= '0;
      right_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
      tie_q    <= tie_d;
      idx_q    <= idx_d;
      right_q  <= right_d;
    end
  end

  assign bus.push          = push_q;
  assign bus.done          = done_q;
  assign bus.tie           = tie_q;
  assign bus.winner_onehot = onehot_q;
  assign bus.winner_idx    = idx_q;
  assign bus.right         = right_q;

endmodule

// File: tb/tb_press_arbiter.sv
// Scoreboard bench for press_arbiter: three configurations driven in
// parallel, a round-level reference model pushes expected results, and a
// negedge monitor pops them whenever a DUT raises done.
module tb_press_arbiter;

  localparam int ND = 3;
  localparam int NP [ND] = '{2, 4, 4};
  localparam int SS [ND] = '{2, 2, 3};
  localparam int TW [ND] = '{0, 3, 5};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] pb_v   [ND];
  logic       clr_v  [ND];
  logic [3:0] oh_v   [ND];
  logic [1:0] idx_v  [ND];
  logic       done_v [ND];
  logic       tie_v  [ND];
  logic       right_v[ND];
  logic       push_v [ND];

  press_arbiter_if #(.N_PLAYERS(2), .IDX_W(1)) if_a ();
  press_arbiter_if #(.N_PLAYERS(4), .IDX_W(2)) if_b ();
  press_arbiter_if #(.N_PLAYERS(4), .IDX_W(2)) if_c ();

  press_arbiter #(.N_PLAYERS(2), .SYNC_STAGES(2), .TIE_WINDOW(0), .IDX_W(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  press_arbiter #(.N_PLAYERS(4), .SYNC_STAGES(2), .TIE_WINDOW(3), .IDX_W(2))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  press_arbiter #(.N_PLAYERS(4), .SYNC_STAGES(3), .TIE_WINDOW(5), .IDX_W(2))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.pb  = pb_v[0][1:0];
  assign if_a.clr = clr_v[0];
  assign if_b.pb  = pb_v[1];
  assign if_b.clr = clr_v[1];
  assign if_c.pb  = pb_v[2];
  assign if_c.clr = clr_v[2];

  assign oh_v[0]    = {2'b00, if_a.winner_onehot};
  assign idx_v[0]   = {1'b0, if_a.winner_idx};
  assign done_v[0]  = if_a.done;
  assign tie_v[0]   = if_a.tie;
  assign right_v[0] = if_a.right;
  assign push_v[0]  = if_a.push;
  assign oh_v[1]    = if_b.winner_onehot;
  assign idx_v[1]   = if_b.winner_idx;
  assign done_v[1]  = if_b.done;
  assign tie_v[1]   = if_b.tie;
  assign right_v[1] = if_b.right;
  assign push_v[1]  = if_b.push;
  assign oh_v[2]    = if_c.winner_onehot;
  assign idx_v[2]   = if_c.winner_idx;
  assign done_v[2]  = if_c.done;
  assign tie_v[2]   = if_c.tie;
  assign right_v[2] = if_c.right;
  assign push_v[2]  = if_c.push;

  typedef struct {
    int         dut;
    logic [3:0] oh;
    logic [1:0] idx;
    logic       tie;
    logic       right;
    int         edge_n;
  } exp_t;

  exp_t sb [$];
  exp_t last_res [ND];

  int checks = 0;
  int errors = 0;

  // Reference model state (round level).
  int         ecount = 16;
  logic [3:0] ring    [ND][8];
  logic [3:0] s_cur   [ND];
  logic [3:0] s_old   [ND];
  int         phase   [ND];   // 0 waiting, 1 collecting, 2 result held
  int         deadline[ND];
  logic [3:0] acc     [ND];
  logic       exp_done[ND];
  logic       exp_push[ND];
  logic       prev_done[ND];

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s got %0h expected %0h", d, nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 8; k++) ring[d][k] = 4'd0;
      s_cur[d]    = 4'd0;
      s_old[d]    = 4'd0;
      phase[d]    = 0;
      acc[d]      = 4'd0;
      exp_done[d] = 1'b0;
      exp_push[d] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model for DUT d.
  task automatic model_step(input int d);
    logic [3:0] rise_in, iso;
    exp_t       e;
    rise_in     = s_cur[d] & ~s_old[d];
    exp_push[d] = |s_cur[d];
    ring[d][ecount % 8] = pb_v[d];
    s_old[d] = s_cur[d];
    s_cur[d] = ring[d][(ecount - SS[d] + 1) % 8];
    if (clr_v[d]) begin
      phase[d]    = 0;
      exp_done[d] = 1'b0;
    end else if (phase[d] == 0) begin
      if (rise_in != 4'd0) begin
        acc[d]      = rise_in;
        deadline[d] = ecount + TW[d];
        phase[d]    = 1;
      end
    end else if (phase[d] == 1) begin
      acc[d] = acc[d] | rise_in;
    end
    if (!clr_v[d] && phase[d] == 1 && ecount == deadline[d]) begin
      iso      = acc[d] & (~acc[d] + 4'd1);
      e.dut    = d;
      e.oh     = acc[d];
      e.idx    = 2'd0;
      for (int k = 0; k < 4; k++) if (iso[k]) e.idx = 2'(k);
      e.tie    = ($countones(acc[d]) >= 2);
      e.right  = (NP[d] == 2) && !e.tie && acc[d][1];
      e.edge_n = ecount;
      sb.push_back(e);
      exp_done[d] = 1'b1;
      phase[d]    = 2;
    end
  endtask

  // Model process: follows every clock edge and asynchronous reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        if (clk) ecount++;
        model_reset();
      end else begin
        ecount++;
        for (int d = 0; d < ND; d++) model_step(d);
      end
    end
  end

  // Monitor: compares levels every cycle and pops the scoreboard on done.
  initial begin
    for (int d = 0; d < ND; d++) prev_done[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk(d, "push", 32'(push_v[d]), 32'(exp_push[d]));
        chk(d, "done_level", 32'(done_v[d]), 32'(exp_done[d]));
        if (done_v[d] && !prev_done[d]) begin
          int hit;
          hit = -1;
          foreach (sb[i]) if (hit < 0 && sb[i].dut == d) hit = i;
          if (hit < 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_done got 1 expected 0", d);
          end else begin
            last_res[d] = sb[hit];
            sb.delete(hit);
            chk(d, "onehot", 32'(oh_v[d]), 32'(last_res[d].oh));
            chk(d, "idx", 32'(idx_v[d]), 32'(last_res[d].idx));
            chk(d, "tie", 32'(tie_v[d]), 32'(last_res[d].tie));
            chk(d, "right", 32'(right_v[d]), 32'(last_res[d].right));
            chk(d, "done_edge", 32'(ecount), 32'(last_res[d].edge_n));
          end
        end else if (done_v[d]) begin
          chk(d, "hold_onehot", 32'(oh_v[d]), 32'(last_res[d].oh));
          chk(d, "hold_idx", 32'(idx_v[d]), 32'(last_res[d].idx));
          chk(d, "hold_tie", 32'(tie_v[d]), 32'(last_res[d].tie));
        end else begin
          chk(d, "idle_tie", 32'(tie_v[d]), 32'd0);
          chk(d, "idle_idx", 32'(idx_v[d]), 32'd0);
          chk(d, "idle_right", 32'(right_v[d]), 32'd0);
        end
        prev_done[d] = done_v[d];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse(input int d);
    clr_v[d] = 1'b1;
    cyc(1);
    clr_v[d] = 1'b0;
    pb_v[d]  = 4'd0;
    cyc(4);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int d = 0; d < ND; d++) begin
      chk(d, {nm, "_done"}, 32'(done_v[d]), 32'd0);
      chk(d, {nm, "_onehot"}, 32'(oh_v[d]), 32'd0);
      chk(d, {nm, "_idx"}, 32'(idx_v[d]), 32'd0);
      chk(d, {nm, "_tie"}, 32'(tie_v[d]), 32'd0);
      chk(d, {nm, "_right"}, 32'(right_v[d]), 32'd0);
      chk(d, {nm, "_push"}, 32'(push_v[d]), 32'd0);
    end
  endtask

  // Stimulus: directed rounds first, then randomized play on all DUTs.
  initial begin
    logic [3:0] msk;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      pb_v[d]  = 4'd0;
      clr_v[d] = 1'b0;
    end
    cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Single press, later second button is ignored.
    pb_v[0] = 4'b0001;
    cyc(6);
    pb_v[0] = 4'b0011;
    cyc(4);
    chk(0, "a1_done", 32'(done_v[0]), 32'd1);
    chk(0, "a1_onehot", 32'(oh_v[0]), 32'd1);
    chk(0, "a1_right", 32'(right_v[0]), 32'd0);
    clr_pulse(0);

    // Simultaneous press is a tie.
    pb_v[0] = 4'b0011;
    cyc(5);
    chk(0, "a2_tie", 32'(tie_v[0]), 32'd1);
    chk(0, "a2_onehot", 32'(oh_v[0]), 32'd3);
    chk(0, "a2_idx", 32'(idx_v[0]), 32'd0);
    clr_pulse(0);

    // Clear while pb[1] held: no capture until a fresh press.
    pb_v[0] = 4'b0010;
    cyc(5);
    clr_v[0] = 1'b1;
    cyc(1);
    clr_v[0] = 1'b0;
    cyc(6);
    chk(0, "a3_held_no_done", 32'(done_v[0]), 32'd0);
    pb_v[0] = 4'd0;
    cyc(4);
    pb_v[0] = 4'b0010;
    cyc(5);
    chk(0, "a3_idx", 32'(idx_v[0]), 32'd1);
    chk(0, "a3_right", 32'(right_v[0]), 32'd1);
    clr_pulse(0);

    // Clear coincides with the capture edge of pb[0]'s rise.
    pb_v[0] = 4'b0001;
    cyc(2);
    clr_v[0] = 1'b1;
    cyc(1);
    clr_v[0] = 1'b0;
    cyc(6);
    chk(0, "a4_discard", 32'(done_v[0]), 32'd0);
    pb_v[0] = 4'b0011;
    cyc(5);
    chk(0, "a4_onehot", 32'(oh_v[0]), 32'd2);
    chk(0, "a4_right", 32'(right_v[0]), 32'd1);
    clr_pulse(0);

    // Tie window: pb[2], pb[0] two cycles later, pb[3] far too late.
    pb_v[1] = 4'b0100;
    cyc(2);
    pb_v[1] = 4'b0101;
    cyc(8);
    pb_v[1] = 4'b1101;
    cyc(4);
    chk(1, "b_onehot", 32'(oh_v[1]), 32'h5);
    chk(1, "b_tie", 32'(tie_v[1]), 32'd1);
    chk(1, "b_idx", 32'(idx_v[1]), 32'd0);
    clr_pulse(1);

    // Reset in the middle of a tie window.
    pb_v[2] = 4'b0010;
    cyc(5);
    chk(2, "c_window_no_done", 32'(done_v[2]), 32'd0);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    for (int d = 0; d < ND; d++) pb_v[d] = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    pb_v[2] = 4'b1000;
    cyc(8);
    chk(2, "c_before_latency", 32'(done_v[2]), 32'd0);
    cyc(1);
    chk(2, "c_at_latency", 32'(done_v[2]), 32'd1);
    chk(2, "c_idx", 32'(idx_v[2]), 32'd3);
    chk(2, "c_onehot", 32'(oh_v[2]), 32'h8);
    clr_pulse(2);

    // Randomized play on all three arbiters.
    repeat (3000) begin
      for (int d = 0; d < ND; d++) begin
        msk = 4'((1 << NP[d]) - 1);
        if ($urandom_range(0, 5) == 0)
          pb_v[d] = (pb_v[d] ^ (4'd1 << $urandom_range(0, NP[d] - 1))) & msk;
        if ($urandom_range(0, 30) == 0)
          pb_v[d] = 4'($urandom) & msk;
        clr_v[d] = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
    end
    for (int d = 0; d < ND; d++) begin
      clr_v[d] = 1'b0;
      pb_v[d]  = 4'd0;
    end
    cyc(20);
    chk(0, "scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
